// File: rtl/miriscv_alu_arbiter.sv
// Two-requester front end for a single miriscv_alu: round-robin or fixed-priority grant,
// one registered response slot per requester with valid/ready drain.

package miriscv_pkg;
  localparam int XLEN = 32;
endpackage

package miriscv_alu_pkg;
  localparam int ALU_OP_W = 5;

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 5'b00000;
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = 5'b00001;
  localparam logic [ALU_OP_W-1:0] ALU_SLTS = 5'b00010;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = 5'b00011;
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = 5'b00100;
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = 5'b00101;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 5'b00110;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 5'b00111;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 5'b01000;
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = 5'b01101;
  localparam logic [ALU_OP_W-1:0] ALU_EQ   = 5'b11000;
  localparam logic [ALU_OP_W-1:0] ALU_NE   = 5'b11001;
  localparam logic [ALU_OP_W-1:0] ALU_LTS  = 5'b11100;
  localparam logic [ALU_OP_W-1:0] ALU_GES  = 5'b11101;
  localparam logic [ALU_OP_W-1:0] ALU_LTU  = 5'b11110;
  localparam logic [ALU_OP_W-1:0] ALU_GEU  = 5'b11111;
endpackage

// Combinational RV32I ALU; branch-compare opcodes drive only the branch flag.
module miriscv_alu
  import miriscv_pkg::*;
  import miriscv_alu_pkg::*;
(
  input  logic [ALU_OP_W-1:0] alu_port_op_i,
  input  logic [XLEN-1:0]     alu_port_a_i,
  input  logic [XLEN-1:0]     alu_port_b_i,
  output logic [XLEN-1:0]     alu_result_o,
  output logic                alu_branch_des_o
);

  logic [4:0] w_shamt;
  assign w_shamt = alu_port_b_i[4:0];

  // NOTE: every output of a combinational block gets a default first so no path infers a latch.
  always_comb begin
    alu_result_o     = alu_port_b_i;
    alu_branch_des_o = 1'b0;
    case (alu_port_op_i)
      ALU_ADD:  alu_result_o = alu_port_a_i + alu_port_b_i;
      ALU_SUB:  alu_result_o = alu_port_a_i - alu_port_b_i;
      ALU_XOR:  alu_result_o = alu_port_a_i ^ alu_port_b_i;
      ALU_OR:   alu_result_o = alu_port_a_i | alu_port_b_i;
      ALU_AND:  alu_result_o = alu_port_a_i & alu_port_b_i;
      ALU_SLL:  alu_result_o = alu_port_a_i << w_shamt;
      ALU_SRL:  alu_result_o = alu_port_a_i >> w_shamt;
      ALU_SRA:  alu_result_o = $unsigned($signed(alu_port_a_i) >>> w_shamt);
      ALU_SLTS: alu_result_o = {{(XLEN-1){1'b0}}, $signed(alu_port_a_i) < $signed(alu_port_b_i)};
      ALU_SLTU: alu_result_o = {{(XLEN-1){1'b0}}, alu_port_a_i < alu_port_b_i};
      ALU_EQ:  begin alu_result_o = '0; alu_branch_des_o = (alu_port_a_i == alu_port_b_i); end
      ALU_NE:  begin alu_result_o = '0; alu_branch_des_o = (alu_port_a_i != alu_port_b_i); end
      ALU_LTS: begin alu_result_o = '0; alu_branch_des_o = $signed(alu_port_a_i) <  $signed(alu_port_b_i); end
      ALU_GES: begin alu_result_o = '0; alu_branch_des_o = $signed(alu_port_a_i) >= $signed(alu_port_b_i); end
      ALU_LTU: begin alu_result_o = '0; alu_branch_des_o = alu_port_a_i <  alu_port_b_i; end
      ALU_GEU: begin alu_result_o = '0; alu_branch_des_o = alu_port_a_i >= alu_port_b_i; end
      default: ;
    endcase
  end

endmodule

module miriscv_alu_arbiter
  import miriscv_pkg::*;
  import miriscv_alu_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req0_valid_i,
  output logic                req0_ready_o,
  input  logic [ALU_OP_W-1:0] req0_op_i,
  input  logic [XLEN-1:0]     req0_a_i,
  input  logic [XLEN-1:0]     req0_b_i,
  output logic                rsp0_valid_o,
  input  logic                rsp0_ready_i,
  output logic [XLEN-1:0]     rsp0_result_o,
  output logic                rsp0_branch_o,
  input  logic                req1_valid_i,
  output logic                req1_ready_o,
  input  logic [ALU_OP_W-1:0] req1_op_i,
  input  logic [XLEN-1:0]     req1_a_i,
  input  logic [XLEN-1:0]     req1_b_i,
  output logic                rsp1_valid_o,
  input  logic                rsp1_ready_i,
  output logic [XLEN-1:0]     rsp1_result_o,
  output logic                rsp1_branch_o
);

  typedef enum logic {SLOT_EMPTY = 1'b0, SLOT_FULL = 1'b1} slot_state_e;

  slot_state_e r_slot0_state, r_slot1_state;
  slot_state_e w_slot0_next,  w_slot1_next;
  logic        r_last_grant;

  logic w_elig0, w_elig1, w_cand0, w_cand1;
  logic w_gnt0, w_gnt1, w_acc0, w_acc1;

  logic [ALU_OP_W-1:0] w_alu_op;
  logic [XLEN-1:0]     w_alu_a, w_alu_b, w_alu_result;
  logic                w_alu_branch;

  // A slot can take a new result if it is empty or being drained on this edge.
  assign w_elig0 = (r_slot0_state == SLOT_EMPTY) | rsp0_ready_i;
  assign w_elig1 = (r_slot1_state == SLOT_EMPTY) | rsp1_ready_i;
  assign w_cand0 = req0_valid_i & w_elig0;
  assign w_cand1 = req1_valid_i & w_elig1;

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (w_cand0 && w_cand1) begin
      if (RR_EN && !r_last_grant) w_gnt1 = 1'b1;
      else                        w_gnt0 = 1'b1;
    end else begin
      w_gnt0 = w_cand0;
      w_gnt1 = w_cand1;
    end
  end

  // Flops are already held in reset, so rst_i only needs to mask the visible ready.
  assign req0_ready_o = w_gnt0 & ~rst_i;
  assign req1_ready_o = w_gnt1 & ~rst_i;
  assign w_acc0       = w_gnt0;
  assign w_acc1       = w_gnt1;

  assign w_alu_op = w_gnt1 ? req1_op_i : req0_op_i;
  assign w_alu_a  = w_gnt1 ? req1_a_i  : req0_a_i;
  assign w_alu_b  = w_gnt1 ? req1_b_i  : req0_b_i;

  miriscv_alu u_alu (
    .alu_port_op_i    (w_alu_op),
    .alu_port_a_i     (w_alu_a),
    .alu_port_b_i     (w_alu_b),
    .alu_result_o     (w_alu_result),
    .alu_branch_des_o (w_alu_branch)
  );

  always_comb begin
    w_slot0_next = r_slot0_state;
    w_slot1_next = r_slot1_state;
    case (r_slot0_state)
      SLOT_EMPTY: if (w_acc0) w_slot0_next = SLOT_FULL;
      SLOT_FULL:  if (rsp0_ready_i && !w_acc0) w_slot0_next = SLOT_EMPTY;
    endcase
    case (r_slot1_state)
      SLOT_EMPTY: if (w_acc1) w_slot1_next = SLOT_FULL;
      SLOT_FULL:  if (rsp1_ready_i && !w_acc1) w_slot1_next = SLOT_EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_slot0_state <= SLOT_EMPTY;
      r_slot1_state <= SLOT_EMPTY;
      r_last_grant  <= 1'b1;
    end else begin
      r_slot0_state <= w_slot0_next;
      r_slot1_state <= w_slot1_next;
      if (w_acc0)      r_last_grant <= 1'b0;
      else if (w_acc1) r_last_grant <= 1'b1;
    end
  end

  // NOTE: result holding registers are reset too, so outputs read zero rather than X after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp0_result_o <= '0;
      rsp0_branch_o <= 1'b0;
      rsp1_result_o <= '0;
      rsp1_branch_o <= 1'b0;
    end else begin
      if (w_acc0) begin
        rsp0_result_o <= w_alu_result;
        rsp0_branch_o <= w_alu_branch;
      end
      if (w_acc1) begin
        rsp1_result_o <= w_alu_result;
        rsp1_branch_o <= w_alu_branch;
      end
    end
  end

  assign rsp0_valid_o = (r_slot0_state == SLOT_FULL);
  assign rsp1_valid_o = (r_slot1_state == SLOT_FULL);

endmodule
